// File: rtl/alu_pkg.sv
// Shared opcodes, widths, FSM state type and instruction layout for the ALU
// sequencing controller.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int OP_W     = 4;
  localparam int INSTR_W  = 16;
  localparam int REG_N    = 4;
  localparam int REG_AW   = 2;

  localparam logic [OP_W-1:0] C_NOP      = 4'h0;
  localparam logic [OP_W-1:0] C_ADD      = 4'h1;
  localparam logic [OP_W-1:0] C_SUB      = 4'h2;
  localparam logic [OP_W-1:0] C_INC      = 4'h3;
  localparam logic [OP_W-1:0] C_DEC      = 4'h4;
  localparam logic [OP_W-1:0] C_OR       = 4'h5;
  localparam logic [OP_W-1:0] C_AND      = 4'h6;
  localparam logic [OP_W-1:0] C_XOR      = 4'h7;
  localparam logic [OP_W-1:0] C_SHR      = 4'h8;
  localparam logic [OP_W-1:0] C_SHL      = 4'h9;
  localparam logic [OP_W-1:0] C_ONESCOMP = 4'hA;
  localparam logic [OP_W-1:0] C_TWOSCOMP = 4'hB;
  localparam logic [OP_W-1:0] C_LDI      = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // imm8 of LDI overlaps rb and the low pad bits
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [5:0]        pad;
  } instr_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= C_ADD) && (op <= C_TWOSCOMP);
  endfunction

  function automatic logic [DATA_W-1:0] imm_of(input instr_t ins);
    return {ins.rb, ins.pad};
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction/result handshakes plus the ALU drive/return lines.
interface alu_ctrl_if;
  import alu_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;
  logic                 res_carry;
  logic                 res_zero;
  logic                 res_err;
  logic [OP_W-1:0]      alu_opcode;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_zero_in;
  logic                 alu_carry_in;

  modport slave (
    input  instr_valid, instr, res_ready, alu_result, alu_zero_in, alu_carry_in,
    output instr_ready, res_valid, res_data, res_carry, res_zero, res_err,
           alu_opcode, alu_a, alu_b
  );

  modport master (
    output instr_valid, instr, res_ready, alu_result, alu_zero_in, alu_carry_in,
    input  instr_ready, res_valid, res_data, res_carry, res_zero, res_err,
           alu_opcode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_ctrl.sv
// Accepts one instruction at a time, drives the external ALU for one cycle,
// writes back into the local register file and returns result plus flags.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  alu_ctrl_if.slave   bus
);

  state_t              state_q;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic                instr_ready_q;
  logic [OP_W-1:0]     alu_opcode_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                res_carry_q;
  logic                res_zero_q;
  logic                res_err_q;

  instr_t              instr_f;
  logic [DATA_W-1:0]   rdata_a;
  logic [DATA_W-1:0]   rdata_b;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  assign instr_f = instr_t'(bus.instr);

  // Writeback lands on the edge that ends EXEC, together with the result.
  assign rf_we    = (state_q == EXEC) && (is_alu_op(op_q) || (op_q == C_LDI));
  assign rf_wdata = (op_q == C_LDI) ? imm_q : bus.alu_result;

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (reset_n),
    .raddr_a_i (instr_f.ra),
    .raddr_b_i (instr_f.rb),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rd_q),
    .wdata_i   (rf_wdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= C_NOP;
      rd_q          <= '0;
      imm_q         <= '0;
      instr_ready_q <= 1'b1;
      alu_opcode_q  <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_carry_q   <= 1'b0;
      res_zero_q    <= 1'b0;
      res_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q          <= instr_f.op;
            rd_q          <= instr_f.rd;
            imm_q         <= imm_of(instr_f);
            instr_ready_q <= 1'b0;
            state_q       <= EXEC;
            // Operands are captured here, so a write to ra/rb cannot disturb them.
            if (is_alu_op(instr_f.op)) begin
              alu_opcode_q <= instr_f.op;
              alu_a_q      <= rdata_a;
              alu_b_q      <= rdata_b;
            end else begin
              alu_opcode_q <= '0;
              alu_a_q      <= '0;
              alu_b_q      <= '0;
            end
          end
        end

        EXEC: begin
          alu_opcode_q <= '0;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          res_valid_q  <= 1'b1;
          state_q      <= RESP;
          if (is_alu_op(op_q)) begin
            res_data_q  <= bus.alu_result;
            res_carry_q <= bus.alu_carry_in;
            res_zero_q  <= bus.alu_zero_in;
            res_err_q   <= 1'b0;
          end else if (op_q == C_LDI) begin
            res_data_q  <= imm_q;
            res_carry_q <= 1'b0;
            res_zero_q  <= (imm_q == '0);
            res_err_q   <= 1'b0;
          end else begin
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_err_q   <= (op_q != C_NOP);
          end
        end

        RESP: begin
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end

        default: begin
          state_q       <= IDLE;
          instr_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_carry   = res_carry_q;
  assign bus.res_zero    = res_zero_q;
  assign bus.res_err     = res_err_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a small combinational ALU beside it.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_ctrl_if bus();

  alu_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] seen_op;
  logic [7:0] seen_a;
  logic [7:0] seen_b;
  logic [8:0] alu_wide;

  // Sibling ALU: carry is carry-out for ADD/INC, borrow for SUB/DEC, shifted-out bit for shifts.
  always_comb begin
    alu_wide = 9'd0;
    case (bus.alu_opcode)
      4'h1: alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'h2: alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'h3: alu_wide = {1'b0, bus.alu_a} + 9'd1;
      4'h4: alu_wide = {1'b0, bus.alu_a} - 9'd1;
      4'h5: alu_wide = {1'b0, bus.alu_a | bus.alu_b};
      4'h6: alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      4'h7: alu_wide = {1'b0, bus.alu_a ^ bus.alu_b};
      4'h8: alu_wide = {bus.alu_a[0], 1'b0, bus.alu_a[7:1]};
      4'h9: alu_wide = {bus.alu_a, 1'b0};
      4'hA: alu_wide = {1'b0, ~bus.alu_a};
      4'hB: alu_wide = {1'b0, (~bus.alu_a) + 8'd1};
      default: alu_wide = 9'd0;
    endcase
    bus.alu_result   = alu_wide[7:0];
    bus.alu_carry_in = alu_wide[8];
    bus.alu_zero_in  = (alu_wide[7:0] == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".instr_ready"}, 32'(bus.instr_ready), 32'd1);
    check({tag, ".res_valid"},   32'(bus.res_valid),   32'd0);
    check({tag, ".res_data"},    32'(bus.res_data),    32'd0);
    check({tag, ".res_err"},     32'(bus.res_err),     32'd0);
    check({tag, ".alu_opcode"},  32'(bus.alu_opcode),  32'd0);
    check({tag, ".alu_a"},       32'(bus.alu_a),       32'd0);
    check({tag, ".alu_b"},       32'(bus.alu_b),       32'd0);
  endtask

  // Full transaction with res_ready held high: accept, EXEC, RESP handshake.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic [7:0] e_data,
                           input logic e_carry, input logic e_zero, input logic e_err);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    seen_op = bus.alu_opcode;
    seen_a  = bus.alu_a;
    seen_b  = bus.alu_b;
    check({tag, ".exec_valid"}, 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, ".data"},      32'(bus.res_data),  32'(e_data));
    check({tag, ".carry"},     32'(bus.res_carry), 32'(e_carry));
    check({tag, ".zero"},      32'(bus.res_zero),  32'(e_zero));
    check({tag, ".err"},       32'(bus.res_err),   32'(e_err));
    $display("[TB] %s instr=%04h data=%02h c=%0d z=%0d e=%0d", tag, ins,
             bus.res_data, bus.res_carry, bus.res_zero, bus.res_err);
    @(posedge clk); #1;
    check({tag, ".done_valid"}, 32'(bus.res_valid),   32'd0);
    check({tag, ".done_ready"}, 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.res_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    run_instr("ldi_r1_ff", 16'hF4FF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_instr("ldi_r2_02", 16'hF802, 8'h02, 1'b0, 1'b0, 1'b0);
    run_instr("add_r3",    16'h1D80, 8'h01, 1'b1, 1'b0, 1'b0);
    check("add.alu_opcode", 32'(seen_op), 32'h1);
    check("add.alu_a",      32'(seen_a),  32'hFF);
    check("add.alu_b",      32'(seen_b),  32'h02);

    // Backpressure: result held for 5 cycles, a stray instruction must be dropped.
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h1D80;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.valid0", 32'(bus.res_valid), 32'd1);
    check("bp.data0",  32'(bus.res_data),  32'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.instr_valid = (i == 2);
      bus.instr       = 16'hFC77;
      @(posedge clk); #1;
      check("bp.hold_valid", 32'(bus.res_valid),   32'd1);
      check("bp.hold_data",  32'(bus.res_data),    32'h01);
      check("bp.hold_carry", 32'(bus.res_carry),   32'd1);
      check("bp.hold_ready", 32'(bus.instr_ready), 32'd0);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clk); #1;
    check("bp.hs_valid", 32'(bus.res_valid),   32'd0);
    check("bp.hs_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;
    check("bp.single", 32'(bus.res_valid), 32'd0);
    $display("[TB] backpressure transaction complete");
    run_instr("or_r3_chk", 16'h53C0, 8'h01, 1'b0, 1'b0, 1'b0);

    run_instr("ldi_r1_05", 16'hF405, 8'h05, 1'b0, 1'b0, 1'b0);
    run_instr("ldi_r2_03", 16'hF803, 8'h03, 1'b0, 1'b0, 1'b0);
    run_instr("sub_r0",    16'h2240, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_instr("xor_r3",    16'h7D80, 8'h06, 1'b0, 1'b0, 1'b0);
    run_instr("shr_r3",    16'h8D00, 8'h02, 1'b1, 1'b0, 1'b0);
    run_instr("dec_r0",    16'h4000, 8'hFD, 1'b0, 1'b0, 1'b0);
    run_instr("ldi_r1_ff2", 16'hF4FF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_instr("inc_r0",    16'h3100, 8'h00, 1'b1, 1'b1, 1'b0);

    run_instr("illegal_c", 16'hC400, 8'h00, 1'b0, 1'b0, 1'b1);
    check("illegal.alu_opcode", 32'(seen_op), 32'h0);
    run_instr("or_r1_chk", 16'h5940, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_instr("nop",       16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    run_instr("ldi_zero",  16'hF000, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset while idle clears the register file.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_idle");
    @(negedge clk);
    reset_n = 1'b1;
    run_instr("or_after_rst", 16'h5180, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during EXEC of LDI r3,0xAA discards it.
    run_instr("ldi_r3_11", 16'hFC11, 8'h11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'hFCAA;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("rst_exec.in_exec", 32'(bus.instr_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    @(posedge clk); #1;
    check("rst_exec.valid_after", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset during EXEC applied");
    run_instr("or_r3_after", 16'h53C0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
